// File: rtl/cp0_core.sv
// rtl/cp0_core.sv - Coprocessor-0 control block: SR/Cause/EPC/PRId, exception and interrupt request
//
// Ports:
//   clk          in   1   single clock, state updates on rising edge
//   reset        in   1   asynchronous active-high clear of all state
//   we           in   1   mtc0 in M stage
//   cp0_addr     in   5   register number (12 SR, 13 Cause, 14 EPC, 15 PRId)
//   cp0_wdata    in  32   mtc0 write data
//   cp0_rdata    out 32   mfc0 read data, combinational
//   vpc          in  32   PC of the instruction in M
//   bd_in        in   1   M instruction is in a branch delay slot
//   exc_code_in  in   5   synchronous exception code, 0 = none
//   hw_int       in   6   external interrupt lines, level-sensitive
//   eret         in   1   eret in M stage
//   int_req      out  1   pipeline flush/redirect request, combinational
//   epc_out      out 32   current EPC
//   handler_pc   out 32   exception entry address (constant)
module cp0_core #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL   = 32'h2024_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        int_req,
  output logic [31:0] epc_out,
  output logic [31:0] handler_pc
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic        int_pend;
  logic        exc_pend;
  logic [31:0] vpc_aligned;
  logic [31:0] epc_target;
  logic [31:0] wdata_aligned;

  // ---------------------------------------------------------------------
  // Request logic. EXL masks both sources so the handler is never
  // re-entered; reset gates the request so the pipeline is not flushed
  // while state is being cleared.
  // ---------------------------------------------------------------------
  always_comb begin
    int_pend = (|(hw_int & im_q)) & ie_q & ~exl_q;
    exc_pend = (exc_code_in != 5'd0) & ~exl_q;
    int_req  = (int_pend | exc_pend) & ~reset;
  end

  // A delay-slot instruction restarts at its branch, one word earlier.
  always_comb begin
    vpc_aligned   = vpc & 32'hFFFF_FFFC;
    wdata_aligned = cp0_wdata & 32'hFFFF_FFFC;
    if (bd_in) begin
      epc_target = vpc_aligned - 32'd4;
    end else begin
      epc_target = vpc_aligned;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state: int_req > eret > we. Cause.IP tracks hw_int every edge,
  // regardless of which (if any) of the above is active.
  // ---------------------------------------------------------------------
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    ip_d       = hw_int;

    if (int_req) begin
      exl_d = 1'b1;
      bd_d  = bd_in;
      epc_d = epc_target;
      // Interrupt takes precedence over a simultaneous synchronous exception.
      if (int_pend) begin
        exc_code_d = 5'd0;
      end else begin
        exc_code_d = exc_code_in;
      end
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (we) begin
      case (cp0_addr)
        ADDR_SR: begin
          im_d  = cp0_wdata[15:10];
          exl_d = cp0_wdata[1];
          ie_d  = cp0_wdata[0];
        end
        ADDR_EPC: begin
          epc_d = wdata_aligned;
        end
        default: begin
          // Cause, PRId and unmapped registers are not writable.
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // ---------------------------------------------------------------------
  // Read mux. Reads see registered state only, so an mfc0 paired with an
  // mtc0 in the same cycle returns the pre-write value.
  // ---------------------------------------------------------------------
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
      ADDR_CAUSE: cp0_rdata = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
      ADDR_EPC:   cp0_rdata = epc_q;
      ADDR_PRID:  cp0_rdata = PRID_VAL;
      default:    cp0_rdata = 32'd0;
    endcase
  end

  assign epc_out    = epc_q;
  assign handler_pc = HANDLER_PC;

endmodule
